// File: rtl/tone_decoder.sv
// Tone decoder: measures the period of an incoming square-wave tone in clk
// cycles, classifies it against the tune's note table, reports each finished
// note with its locked duration and flags the complete eight-note tune.
module tone_decoder #(
  parameter int unsigned TOL    = 64,
  parameter int unsigned STABLE = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tone_in,
  output logic [2:0]  cur_note,
  output logic        note_vld,
  output logic [2:0]  note_code,
  output logic [23:0] note_dur,
  output logic        tune_det
);

  localparam int unsigned MW = $clog2(STABLE + 1);
  localparam logic [MW-1:0] STABLE_M = MW'(STABLE);
  localparam logic signed [15:0] TOL_S = $signed(16'(TOL));

  localparam logic [2:0] CODE_NONE = 3'd0;
  localparam logic [2:0] CODE_D7   = 3'd1;
  localparam logic [2:0] CODE_E7   = 3'd2;
  localparam logic [2:0] CODE_F7   = 3'd3;
  localparam logic [2:0] CODE_A6   = 3'd4;

  localparam logic [15:0] NOM_D7 = 16'h5326;
  localparam logic [15:0] NOM_E7 = 16'h4A11;
  localparam logic [15:0] NOM_F7 = 16'h45E7;
  localparam logic [15:0] NOM_A6 = 16'h6EF9;

  localparam logic [14:0] CNT_MAX = 15'h7FFF;
  localparam logic [14:0] CNT_PRE = 15'h7FFE;

  typedef enum logic [2:0] {IDLE, S1, S2, S3, S4, S5, S6, S7} seq_state_t;

  function automatic logic in_win(input logic [15:0] p, input logic [15:0] nom);
    logic signed [15:0] d;
    d = $signed(p - nom);
    return (d <= TOL_S) && (d >= -TOL_S);
  endfunction

  function automatic logic [2:0] classify(input logic [15:0] p);
    if (in_win(p, NOM_D7)) return CODE_D7;
    if (in_win(p, NOM_E7)) return CODE_E7;
    if (in_win(p, NOM_F7)) return CODE_F7;
    if (in_win(p, NOM_A6)) return CODE_A6;
    return CODE_NONE;
  endfunction

  logic          tone_s1_q, tone_s1_d;
  logic          tone_s2_q, tone_s2_d;
  logic          tone_prev_q, tone_prev_d;
  logic          rise_q, rise_d;
  logic [14:0]   cnt_q, cnt_d;
  logic          have_edge_q, have_edge_d;
  logic [2:0]    cand_q, cand_d;
  logic [MW-1:0] match_q, match_d;
  logic [2:0]    cur_note_q, cur_note_d;
  logic [23:0]   dur_q, dur_d;
  logic          note_vld_q, note_vld_d;
  logic [2:0]    note_code_q, note_code_d;
  logic [23:0]   note_dur_q, note_dur_d;
  seq_state_t    state_q, state_d;
  logic          tune_det_d, tune_det_q;

  logic          silence;
  logic          meas;
  logic [15:0]   period;
  logic [2:0]    code;
  logic          lock;
  logic          end_note;
  logic [2:0]    exp_code;

  // Synchronizer, edge register and registered rise strobe.
  always_comb begin
    tone_s1_d   = tone_in;
    tone_s2_d   = tone_s1_q;
    tone_prev_d = tone_s2_q;
    rise_d      = tone_s2_q & ~tone_prev_q;
  end

  // Period measurement, classification, note lock/end and duration tracking.
  // A rise on the same cycle the counter would saturate wins over silence.
  always_comb begin
    silence  = ~rise_q && (cnt_q == CNT_PRE);
    meas     = rise_q && have_edge_q;
    period   = {1'b0, cnt_q} + 16'd1;
    code     = classify(period);

    cnt_d       = rise_q ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 15'd1);
    have_edge_d = have_edge_q;
    if (rise_q)       have_edge_d = 1'b1;
    else if (silence) have_edge_d = 1'b0;

    cand_d  = cand_q;
    match_d = match_q;
    if (meas) begin
      if (code == cand_q) begin
        match_d = (match_q == STABLE_M) ? match_q : match_q + 1'b1;
      end else begin
        cand_d  = code;
        match_d = MW'(1);
      end
    end else if (silence) begin
      cand_d  = CODE_NONE;
      match_d = '0;
    end

    lock     = 1'b0;
    end_note = 1'b0;
    if (meas && match_d == STABLE_M) begin
      if (cand_d != CODE_NONE && cand_d != cur_note_q) begin
        lock     = 1'b1;
        end_note = (cur_note_q != CODE_NONE);
      end else if (cand_d == CODE_NONE && cur_note_q != CODE_NONE) begin
        end_note = 1'b1;
      end
    end
    if (silence && cur_note_q != CODE_NONE) end_note = 1'b1;

    cur_note_d = cur_note_q;
    if (lock)          cur_note_d = cand_d;
    else if (end_note) cur_note_d = CODE_NONE;

    dur_d = dur_q;
    if (lock)                                          dur_d = '0;
    else if (cur_note_q != CODE_NONE && dur_q != '1)   dur_d = dur_q + 24'd1;

    note_vld_d  = end_note;
    note_code_d = end_note ? cur_note_q : note_code_q;
    note_dur_d  = end_note ? dur_q : note_dur_q;
  end

  // Tune sequence recogniser: advances on each matching ended note.
  always_comb begin
    state_d    = state_q;
    tune_det_d = 1'b0;
    case (state_q)
      IDLE:    exp_code = CODE_D7;
      S1:      exp_code = CODE_E7;
      S2:      exp_code = CODE_F7;
      S3:      exp_code = CODE_E7;
      S4:      exp_code = CODE_F7;
      S5:      exp_code = CODE_D7;
      S6:      exp_code = CODE_A6;
      S7:      exp_code = CODE_D7;
      default: exp_code = CODE_D7;
    endcase
    if (note_vld_q) begin
      if (note_code_q == exp_code) begin
        case (state_q)
          IDLE:    state_d = S1;
          S1:      state_d = S2;
          S2:      state_d = S3;
          S3:      state_d = S4;
          S4:      state_d = S5;
          S5:      state_d = S6;
          S6:      state_d = S7;
          S7: begin
            state_d    = IDLE;
            tune_det_d = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end else begin
        state_d = (note_code_q == CODE_D7) ? S1 : IDLE;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_s1_q   <= 1'b0;
      tone_s2_q   <= 1'b0;
      tone_prev_q <= 1'b0;
      rise_q      <= 1'b0;
      cnt_q       <= '0;
      have_edge_q <= 1'b0;
      cand_q      <= '0;
      match_q     <= '0;
      cur_note_q  <= '0;
      dur_q       <= '0;
      note_vld_q  <= 1'b0;
      note_code_q <= '0;
      note_dur_q  <= '0;
      state_q     <= IDLE;
      tune_det_q  <= 1'b0;
    end else begin
      tone_s1_q   <= tone_s1_d;
      tone_s2_q   <= tone_s2_d;
      tone_prev_q <= tone_prev_d;
      rise_q      <= rise_d;
      cnt_q       <= cnt_d;
      have_edge_q <= have_edge_d;
      cand_q      <= cand_d;
      match_q     <= match_d;
      cur_note_q  <= cur_note_d;
      dur_q       <= dur_d;
      note_vld_q  <= note_vld_d;
      note_code_q <= note_code_d;
      note_dur_q  <= note_dur_d;
      state_q     <= state_d;
      tune_det_q  <= tune_det_d;
    end
  end

  assign cur_note  = cur_note_q;
  assign note_vld  = note_vld_q;
  assign note_code = note_code_q;
  assign note_dur  = note_dur_q;
  assign tune_det  = tune_det_q;

endmodule

// File: tb/tb_tone_decoder.sv
// Bench for tone_decoder: directed scenarios with randomized period jitter,
// checked against an event-level reference model of the note/tune rules.
module tb_tone_decoder;

  localparam int TOL    = 64;
  localparam int STABLE = 3;
  localparam int SIL    = 32'h7FFF;
  localparam int P_D7   = 32'h5326;
  localparam int P_E7   = 32'h4A11;
  localparam int P_F7   = 32'h45E7;
  localparam int P_A6   = 32'h6EF9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tone_in;
  logic [2:0]  cur_note;
  logic        note_vld;
  logic [2:0]  note_code;
  logic [23:0] note_dur;
  logic        tune_det;

  tone_decoder #(.TOL(TOL), .STABLE(STABLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tone_in   (tone_in),
    .cur_note  (cur_note),
    .note_vld  (note_vld),
    .note_code (note_code),
    .note_dur  (note_dur),
    .tune_det  (tune_det)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Observed events (edge number after which the output was seen).
  int o_vld_cyc[$];
  int o_vld_code[$];
  int o_vld_dur[$];
  int o_tune_cyc[$];
  int o_cur_cyc[$];
  int o_cur_val[$];
  logic [2:0] cur_prev = '0;

  always @(negedge clk) begin
    if (note_vld === 1'b1) begin
      o_vld_cyc.push_back(cyc);
      o_vld_code.push_back(int'(note_code));
      o_vld_dur.push_back(int'(note_dur));
    end
    if (tune_det === 1'b1) o_tune_cyc.push_back(cyc);
    if (cur_note !== cur_prev) begin
      o_cur_cyc.push_back(cyc);
      o_cur_val.push_back(int'(cur_note));
    end
    cur_prev <= cur_note;
  end

  // Stimulus record: clock edge at which each driven rise takes effect.
  int rises[$];

  // Expected events.
  int e_vld_cyc[$];
  int e_vld_code[$];
  int e_vld_dur[$];
  int e_tune_cyc[$];
  int e_cur_cyc[$];
  int e_cur_val[$];
  int tune_seq[8] = '{1, 2, 3, 2, 3, 1, 4, 1};
  int tpos;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    tone_in = 1'b0;
    repeat (n) step();
  endtask

  // One tone cycle of p clk: rise now, fall at half period.
  task automatic tone_period(input int p);
    tone_in = 1'b1;
    rises.push_back(cyc + 4);
    repeat (p / 2) step();
    tone_in = 1'b0;
    repeat (p - p / 2) step();
  endtask

  function automatic int nominal_of(input int code);
    case (code)
      1: return P_D7;
      2: return P_E7;
      3: return P_F7;
      4: return P_A6;
      default: return 0;
    endcase
  endfunction

  task automatic play_note(input int code, input int n, input bit jit);
    int p;
    for (int k = 0; k < n; k++) begin
      p = nominal_of(code);
      if (jit) p = p + int'($urandom_range(0, 2 * TOL)) - TOL;
      tone_period(p);
    end
  endtask

  task automatic clear_obs();
    o_vld_cyc.delete();  o_vld_code.delete(); o_vld_dur.delete();
    o_tune_cyc.delete(); o_cur_cyc.delete();  o_cur_val.delete();
  endtask

  task automatic start_scn();
    rst_n   = 1'b0;
    tone_in = 1'b0;
    step();
    step();
    clear_obs();
    rises.delete();
    step();
    rst_n = 1'b1;
    step();
  endtask

  function automatic int classify_ref(input int p);
    int nom;
    for (int c = 1; c <= 4; c++) begin
      nom = nominal_of(c);
      if (((p > nom) ? p - nom : nom - p) <= TOL) return c;
    end
    return 0;
  endfunction

  task automatic model_end(input int e, input int code, input int lk);
    int d;
    d = e - 1 - lk;
    if (d > 32'hFFFFFF) d = 32'hFFFFFF;
    e_vld_cyc.push_back(e);
    e_vld_code.push_back(code);
    e_vld_dur.push_back(d);
    if (code == tune_seq[tpos]) begin
      tpos++;
      if (tpos == 8) begin
        e_tune_cyc.push_back(e + 1);
        tpos = 0;
      end
    end else begin
      tpos = (code == 1) ? 1 : 0;
    end
  endtask

  // Reference: walk the rise times; silence is 0x7FFF clk after the last
  // rise with no newer rise; a rise landing exactly there still counts.
  task automatic run_model(input int t_end);
    int have, last, cand, match, cur, lk, a, p, c;
    have = 0; last = 0; cand = 0; match = 0; cur = 0; lk = 0; tpos = 0;
    e_vld_cyc.delete();  e_vld_code.delete(); e_vld_dur.delete();
    e_tune_cyc.delete(); e_cur_cyc.delete();  e_cur_val.delete();
    for (int i = 0; i < rises.size(); i++) begin
      a = rises[i];
      if (have != 0 && a > last + SIL) begin
        if (cur != 0) begin
          model_end(last + SIL, cur, lk);
          cur = 0;
          e_cur_cyc.push_back(last + SIL);
          e_cur_val.push_back(0);
        end
        have = 0; cand = 0; match = 0;
      end
      if (have == 0) begin
        have = 1;
        last = a;
      end else begin
        p    = a - last;
        last = a;
        c    = classify_ref(p);
        if (c == cand) match = (match < STABLE) ? match + 1 : STABLE;
        else begin
          cand  = c;
          match = 1;
        end
        if (match == STABLE) begin
          if (cand != 0 && cand != cur) begin
            if (cur != 0) model_end(a, cur, lk);
            cur = cand;
            lk  = a;
            e_cur_cyc.push_back(a);
            e_cur_val.push_back(cand);
          end else if (cand == 0 && cur != 0) begin
            model_end(a, cur, lk);
            cur = 0;
            e_cur_cyc.push_back(a);
            e_cur_val.push_back(0);
          end
        end
      end
    end
    if (have != 0 && last + SIL <= t_end && cur != 0) begin
      model_end(last + SIL, cur, lk);
      e_cur_cyc.push_back(last + SIL);
      e_cur_val.push_back(0);
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_n_vld"}, o_vld_cyc.size(), e_vld_cyc.size());
    for (int i = 0; i < o_vld_cyc.size() && i < e_vld_cyc.size(); i++) begin
      chk($sformatf("%s_vld%0d_cyc", tag, i), o_vld_cyc[i], e_vld_cyc[i]);
      chk($sformatf("%s_vld%0d_code", tag, i), o_vld_code[i], e_vld_code[i]);
      chk($sformatf("%s_vld%0d_dur", tag, i), o_vld_dur[i], e_vld_dur[i]);
    end
    chk({tag, "_n_tune"}, o_tune_cyc.size(), e_tune_cyc.size());
    for (int i = 0; i < o_tune_cyc.size() && i < e_tune_cyc.size(); i++)
      chk($sformatf("%s_tune%0d_cyc", tag, i), o_tune_cyc[i], e_tune_cyc[i]);
    chk({tag, "_n_cur"}, o_cur_cyc.size(), e_cur_cyc.size());
    for (int i = 0; i < o_cur_cyc.size() && i < e_cur_cyc.size(); i++) begin
      chk($sformatf("%s_cur%0d_cyc", tag, i), o_cur_cyc[i], e_cur_cyc[i]);
      chk($sformatf("%s_cur%0d_val", tag, i), o_cur_val[i], e_cur_val[i]);
    end
  endtask

  function automatic int first_or_neg(input int q[$], input int idx);
    return (q.size() > idx) ? q[idx] : -1;
  endfunction

  int broken_seq[11] = '{1, 2, 4, 1, 2, 3, 2, 3, 1, 4, 1};

  initial begin
    rst_n   = 1'b0;
    tone_in = 1'b0;
    step();

    // Reset held while the tone toggles.
    for (int i = 0; i < 40; i++) begin
      if (i % 4 == 0) tone_in = ~tone_in;
      step();
    end
    chk("rst_cur_note", cur_note, 0);
    chk("rst_note_vld", note_vld, 0);
    chk("rst_note_code", note_code, 0);
    chk("rst_note_dur", note_dur, 0);
    chk("rst_tune_det", tune_det, 0);

    // Single D7 note, exact period, ended by silence.
    start_scn();
    play_note(1, 11, 1'b0);
    idle(SIL + 40);
    run_model(cyc);
    compare_all("single");
    chk("single_code", first_or_neg(o_vld_code, 0), 1);

    // Window edges: D7-64 locks, E7+64 takes over, then a rise spaced
    // exactly 0x7FFF after the previous one (rise, not silence).
    start_scn();
    play_note(1, 1, 1'b0);
    for (int k = 0; k < 4; k++) tone_period(P_D7 - TOL);
    for (int k = 0; k < 4; k++) tone_period(P_E7 + TOL);
    tone_period(SIL);
    tone_period(P_E7 + TOL);
    idle(SIL + 40);
    run_model(cyc);
    compare_all("tol_in");
    chk("tol_in_first_lock", first_or_neg(o_cur_val, 0), 1);
    chk("tol_in_second_lock", first_or_neg(o_cur_val, 1), 2);

    // Just outside the windows: nothing locks.
    start_scn();
    for (int k = 0; k < 5; k++) tone_period(P_E7 + TOL + 1);
    for (int k = 0; k < 4; k++) tone_period(P_D7 - TOL - 1);
    idle(SIL + 40);
    chk("tol_out_n_vld", o_vld_cyc.size(), 0);
    chk("tol_out_n_cur", o_cur_cyc.size(), 0);

    // Back-to-back F7 -> A6 with no gap.
    start_scn();
    play_note(3, 5, 1'b1);
    play_note(4, 5, 1'b1);
    idle(SIL + 40);
    run_model(cyc);
    compare_all("b2b");
    chk("b2b_first_code", first_or_neg(o_vld_code, 0), 3);

    // Reset in the middle of a locked note discards it.
    start_scn();
    play_note(1, 5, 1'b1);
    rst_n = 1'b0;
    step();
    chk("midrst_cur_note", cur_note, 0);
    chk("midrst_note_vld", note_vld, 0);
    step();
    rst_n = 1'b1;
    play_note(1, 2, 1'b1);
    idle(SIL + 40);
    chk("midrst_n_vld", o_vld_cyc.size(), 0);
    chk("midrst_n_cur", o_cur_cyc.size(), 2);
    chk("midrst_lock_val", first_or_neg(o_cur_val, 0), 1);

    // Full tune with silence gaps.
    start_scn();
    for (int n = 0; n < 8; n++) begin
      play_note(tune_seq[n], 4, 1'b1);
      idle(SIL + int'($urandom_range(0, 100)));
    end
    idle(40);
    run_model(cyc);
    compare_all("tune");
    chk("tune_n_det", o_tune_cyc.size(), 1);
    for (int n = 0; n < 8; n++)
      chk($sformatf("tune_code%0d", n), first_or_neg(o_vld_code, n), tune_seq[n]);

    // Broken start, then the full tune, all back-to-back.
    start_scn();
    for (int n = 0; n < 11; n++) play_note(broken_seq[n], 4, 1'b1);
    idle(SIL + 40);
    run_model(cyc);
    compare_all("broken");
    chk("broken_n_det", o_tune_cyc.size(), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_decoder.md
# tone_decoder

Receive-side counterpart of the piezo tune generator. Samples an incoming square-wave tone and measures each period in clk cycles. Classifies the period against the tune's note table and reports each completed note with its duration. Also detects the complete eight-note tune sequence. Used for loopback self-test of the buzzer path and for bench checking of the player.

## Interface
- TOL, 64: allowed ± error in clk cycles when matching a measured period to a nominal period.
- STABLE, 3: consecutive matching periods required to lock a note; also consecutive unmatched periods required to end one.
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- tone_in  in  1  square-wave tone input, asynchronous to clk.
- cur_note  out  3  currently locked note code (0 = none).
- note_vld  out  1  one-cycle pulse: a note has ended; note_code/note_dur are valid this cycle.
- note_code  out  3  code of the ended note.
- note_dur  out  24  clk cycles the ended note was locked (saturating).
- tune_det  out  1  one-cycle pulse: full tune sequence received.

## Operation
- Note codes and nominal periods:
  - 1 = D7, 0x5326
  - 2 = E7, 0x4A11
  - 3 = F7, 0x45E7
  - 4 = A6, 0x6EF9
  - 0 = none / unmatched.
- Input path: two-flop synchronizer, then an edge register. A rising edge is detected when the synchronized sample is 1 and the previous sample is 0.
- Period counter (15 bit):
  - Increments every cycle and saturates at 0x7FFF.
  - On a detected rise: measured period = cnt + 1, and the counter clears to 0.
  - If the counter reaches 0x7FFF with no rise, that is a silence event. The next rise only re-arms measurement and yields no period (have_edge flag).
- Classification:
  - code = n if |period − nominal_n| ≤ TOL, else 0.
  - Compute the difference in 16-bit signed arithmetic.
  - Windows do not overlap for TOL < 533.
- Lock logic, on each measured period with classified code c:
  - If c == cand, increment match_cnt, saturating at STABLE.
  - Otherwise set cand = c and match_cnt = 1.
  - When match_cnt reaches STABLE with cand ≠ 0 and cand ≠ cur_note, the note locks. If cur_note ≠ 0, the old note ends and the new note locks in the same cycle.
  - When match_cnt reaches STABLE with cand == 0 and cur_note ≠ 0, the note ends.
  - On a silence event with cur_note ≠ 0, the note ends.
- Note end: for one cycle assert note_vld with note_code = cur_note and note_dur = dur_cnt. Then cur_note becomes the newly locked code, or 0.
- Duration counter (24 bit):
  - Cleared to 0 on lock.
  - Increments every cycle while cur_note ≠ 0 and saturates at 0xFFFFFF.
- Sequence FSM:
  - States IDLE, S1..S7. Expected codes in order: D7, E7, F7, E7, F7, D7, A6, D7.
  - Advances only on note_vld whose code matches the expected code.
  - On a mismatch: go to S1 if code == D7, else IDLE.
  - When the 8th note (D7) matches: pulse tune_det, return to IDLE.
  - Duration is not checked.

## Timing
- Reset values: cur_note = 0, note_vld = 0, note_code = 0, note_dur = 0, tune_det = 0. The FSM, period counter, dur_cnt, match_cnt, cand and have_edge all reset to 0 / IDLE.
- Rise detect latency: 3 clk from a tone_in rise to the internal rise strobe.
- Lock: cur_note updates 1 clk after the rise strobe that completes the STABLE-th match.
- note_vld is registered and asserted in the same clk that cur_note changes.
- note_code/note_dur hold their values until the next note_vld.
- tune_det is asserted 1 clk after the final note_vld.
- Boundary conditions:
  - Simultaneous silence event and rise (counter at 0x7FFE when a rise is detected) is a rise, not silence.
  - A note end and a new lock in the same cycle produce exactly one note_vld, for the old note.
  - A period of exactly nominal ± TOL matches; ± (TOL+1) does not.
  - rst_n asserted mid-note discards the note: no note_vld.

## Test plan
- Reset: hold rst_n low with tone_in toggling → all outputs 0. After release, no note_vld until STABLE periods are received.
- Single note: 10 periods of 0x5326, then tone_in held low → cur_note = 1 one clk after the 3rd measured period. note_vld with code 1 and note_dur ≈ 7 × 0x5326 + 0x7FFF (exact value from the bench model) follows the silence.
- Tolerance edges: periods 0x4A11 + 64 → locks E7 (2). Periods 0x4A11 + 65 → cur_note stays 0, no note_vld.
- Back-to-back change: 5 periods at F7, then 5 at A6 with no gap → one note_vld with code 3, and cur_note = 4 in the same cycle.
- Full tune: drive D7, E7, F7, E7, F7, D7, A6, D7 with silence gaps → 8 note_vld pulses with codes 1, 2, 3, 2, 3, 1, 4, 1, and a single tune_det pulse 1 clk after the last.
- Broken sequence with recovery: D7, E7, A6, then the full tune → no tune_det after A6, exactly one tune_det at the end.
